wb_master_arbiter: RTL and testbench

- Two-requester arbiter for the Ethernet MAC's single Wishbone master port.
- Shares the master port between requester 0 (TX buffer fetch) and requester 1 (RX buffer store).
- Round-robin grant on contention; bus ownership is held for a whole cycle, including bursts.
- A stalled-slave watchdog returns a synthesized error to the owning requester.

---
 rtl/wb_master_arbiter.sv | 169 ++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_master_arbiter.sv
// Two-requester Wishbone master arbiter with a stalled-slave watchdog.
// Requester 0 (TX fetch) and requester 1 (RX store) share one master port.
// Ports: wb_clk_i/wb_rst_i (sync active-high reset), r0_*/r1_* requester
// slave-side buses, m_wb_* shared master bus, grant_o (one-hot owner),
// timeout_o (one-cycle pulse, one cycle after the watchdog fires).
module wb_master_arbiter #(
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned WB_SEL_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [WB_ADDR_WIDTH-1:0] r0_adr_i,
    input  logic [WB_SEL_WIDTH-1:0]  r0_sel_i,
    input  logic                     r0_we_i,
    input  logic [WB_DATA_WIDTH-1:0] r0_dat_i,
    input  logic                     r0_cyc_i,
    input  logic                     r0_stb_i,
    input  logic [2:0]               r0_cti_i,
    input  logic [1:0]               r0_bte_i,
    output logic [WB_DATA_WIDTH-1:0] r0_dat_o,
    output logic                     r0_ack_o,
    output logic                     r0_err_o,
    input  logic [WB_ADDR_WIDTH-1:0] r1_adr_i,
    input  logic [WB_SEL_WIDTH-1:0]  r1_sel_i,
    input  logic                     r1_we_i,
    input  logic [WB_DATA_WIDTH-1:0] r1_dat_i,
    input  logic                     r1_cyc_i,
    input  logic                     r1_stb_i,
    input  logic [2:0]               r1_cti_i,
    input  logic [1:0]               r1_bte_i,
    output logic [WB_DATA_WIDTH-1:0] r1_dat_o,
    output logic                     r1_ack_o,
    output logic                     r1_err_o,
    output logic [WB_ADDR_WIDTH-1:0] m_wb_adr_o,
    output logic [WB_SEL_WIDTH-1:0]  m_wb_sel_o,
    output logic                     m_wb_we_o,
    output logic [WB_DATA_WIDTH-1:0] m_wb_dat_o,
    output logic                     m_wb_cyc_o,
    output logic                     m_wb_stb_o,
    output logic [2:0]               m_wb_cti_o,
    output logic [1:0]               m_wb_bte_o,
    input  logic [WB_DATA_WIDTH-1:0] m_wb_dat_i,
    input  logic                     m_wb_ack_i,
    input  logic                     m_wb_err_i,
    output logic [1:0]               grant_o,
    output logic                     timeout_o
);

    localparam int unsigned WD_W = 16;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS0 = 2'd1,
        BUS1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_q;
    logic            wd_inc;
    logic            wd_fire;

    // Next-state, last-grant and watchdog counter logic
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wd_cnt_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (r0_cyc_i && r1_cyc_i) begin
                    // Tie goes to whoever did not own the bus last
                    state_d = last_grant_q ? BUS0 : BUS1;
                end else if (r0_cyc_i) begin
                    state_d = BUS0;
                end else if (r1_cyc_i) begin
                    state_d = BUS1;
                end
            end
            BUS0: begin
                if (!r0_cyc_i) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            BUS1: begin
                if (!r1_cyc_i) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Count only genuinely stalled strobes; anything else restarts the window
        if (wd_inc && !wd_fire && (state_d == state_q)) begin
            wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wd_cnt_q     <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wd_cnt_q     <= wd_cnt_d;
            timeout_q    <= wd_fire;
        end
    end

    // Master bus mux: owner's inputs pass straight through, idle drives zeros
    always_comb begin
        m_wb_adr_o = '0;
        m_wb_sel_o = '0;
        m_wb_we_o  = 1'b0;
        m_wb_dat_o = '0;
        m_wb_cyc_o = 1'b0;
        m_wb_stb_o = 1'b0;
        m_wb_cti_o = '0;
        m_wb_bte_o = '0;
        grant_o    = 2'b00;
        unique case (state_q)
            BUS0: begin
                m_wb_adr_o = r0_adr_i;
                m_wb_sel_o = r0_sel_i;
                m_wb_we_o  = r0_we_i;
                m_wb_dat_o = r0_dat_i;
                m_wb_cyc_o = r0_cyc_i;
                m_wb_stb_o = r0_stb_i;
                m_wb_cti_o = r0_cti_i;
                m_wb_bte_o = r0_bte_i;
                grant_o    = 2'b01;
            end
            BUS1: begin
                m_wb_adr_o = r1_adr_i;
                m_wb_sel_o = r1_sel_i;
                m_wb_we_o  = r1_we_i;
                m_wb_dat_o = r1_dat_i;
                m_wb_cyc_o = r1_cyc_i;
                m_wb_stb_o = r1_stb_i;
                m_wb_cti_o = r1_cti_i;
                m_wb_bte_o = r1_bte_i;
                grant_o    = 2'b10;
            end
            default: ;
        endcase
    end

    // Stalled strobe: owner still in a cycle, strobing, and the slave silent
    assign wd_inc  = (state_q != IDLE) && m_wb_cyc_o && m_wb_stb_o && !m_wb_ack_i && !m_wb_err_i;
    assign wd_fire = wd_inc && (wd_cnt_q == WD_LAST);

    // Response routing; err (slave or watchdog) overrides ack
    assign r0_dat_o  = m_wb_dat_i;
    assign r1_dat_o  = m_wb_dat_i;
    assign r0_ack_o  = grant_o[0] & m_wb_ack_i & ~m_wb_err_i;
    assign r1_ack_o  = grant_o[1] & m_wb_ack_i & ~m_wb_err_i;
    assign r0_err_o  = grant_o[0] & (m_wb_err_i | wd_fire);
    assign r1_err_o  = grant_o[1] & (m_wb_err_i | wd_fire);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed self-checking bench for wb_master_arbiter (TIMEOUT_CYCLES = 8).
module tb_wb_master_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] r0_adr = '0, r1_adr = '0, r0_dat = '0, r1_dat = '0;
    logic [3:0]  r0_sel = '0, r1_sel = '0;
    logic        r0_we = 1'b0, r1_we = 1'b0;
    logic        r0_cyc = 1'b0, r1_cyc = 1'b0, r0_stb = 1'b0, r1_stb = 1'b0;
    logic [2:0]  r0_cti = '0, r1_cti = '0;
    logic [1:0]  r0_bte = '0, r1_bte = '0;
    logic [31:0] r0_dat_o, r1_dat_o;
    logic        r0_ack_o, r1_ack_o, r0_err_o, r1_err_o;
    logic [31:0] m_adr, m_dat_o;
    logic [3:0]  m_sel;
    logic        m_we, m_cyc, m_stb;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic [31:0] m_dat_i = '0;
    logic        m_ack = 1'b0, m_err = 1'b0;
    logic [1:0]  grant;
    logic        timeout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_master_arbiter #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .WB_SEL_WIDTH  (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i (clk),      .wb_rst_i (rst),
        .r0_adr_i (r0_adr),   .r0_sel_i (r0_sel),   .r0_we_i (r0_we),
        .r0_dat_i (r0_dat),   .r0_cyc_i (r0_cyc),   .r0_stb_i(r0_stb),
        .r0_cti_i (r0_cti),   .r0_bte_i (r0_bte),
        .r0_dat_o (r0_dat_o), .r0_ack_o (r0_ack_o), .r0_err_o(r0_err_o),
        .r1_adr_i (r1_adr),   .r1_sel_i (r1_sel),   .r1_we_i (r1_we),
        .r1_dat_i (r1_dat),   .r1_cyc_i (r1_cyc),   .r1_stb_i(r1_stb),
        .r1_cti_i (r1_cti),   .r1_bte_i (r1_bte),
        .r1_dat_o (r1_dat_o), .r1_ack_o (r1_ack_o), .r1_err_o(r1_err_o),
        .m_wb_adr_o(m_adr),   .m_wb_sel_o(m_sel),   .m_wb_we_o(m_we),
        .m_wb_dat_o(m_dat_o), .m_wb_cyc_o(m_cyc),   .m_wb_stb_o(m_stb),
        .m_wb_cti_o(m_cti),   .m_wb_bte_o(m_bte),
        .m_wb_dat_i(m_dat_i), .m_wb_ack_i(m_ack),   .m_wb_err_i(m_err),
        .grant_o  (grant),    .timeout_o(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0; settle();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_cyc", 32'(m_cyc), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_wdcnt", 32'(dut.wd_cnt_q), 32'h0);

        // r0 single write
        r0_adr = 32'h100; r0_dat = 32'hDEADBEEF; r0_sel = 4'hF; r0_we = 1'b1;
        r0_cyc = 1'b1; r0_stb = 1'b1; settle();
        chk("wr_idle_grant", 32'(grant), 32'h0);
        chk("wr_idle_cyc", 32'(m_cyc), 32'h0);
        tick();
        chk("wr_grant", 32'(grant), 32'h1);
        chk("wr_adr", m_adr, 32'h100);
        chk("wr_dat", m_dat_o, 32'hDEADBEEF);
        chk("wr_sel", 32'(m_sel), 32'hF);
        chk("wr_we", 32'(m_we), 32'h1);
        chk("wr_cyc", 32'(m_cyc), 32'h1);
        chk("wr_noack", 32'(r0_ack_o), 32'h0);
        tick();
        m_ack = 1'b1; settle();
        chk("wr_ack0", 32'(r0_ack_o), 32'h1);
        chk("wr_ack1", 32'(r1_ack_o), 32'h0);
        tick();
        m_ack = 1'b0; r0_cyc = 1'b0; r0_stb = 1'b0; r0_we = 1'b0; settle();
        chk("wr_ack0_off", 32'(r0_ack_o), 32'h0);
        chk("wr_rel_grant", 32'(grant), 32'h1);
        chk("wr_rel_cyc", 32'(m_cyc), 32'h0);
        tick();
        chk("wr_idle_after", 32'(grant), 32'h0);

        // Simultaneous requests straight out of reset
        rst = 1'b1; tick(); rst = 1'b0;
        r0_cyc = 1'b1; r0_stb = 1'b1; r1_cyc = 1'b1; r1_stb = 1'b1;
        r1_adr = 32'h200;
        tick();
        chk("tie1_grant", 32'(grant), 32'h1);
        m_ack = 1'b1; m_dat_i = 32'hA5A5_0001; settle();
        chk("tie1_ack0", 32'(r0_ack_o), 32'h1);
        chk("tie1_ack1", 32'(r1_ack_o), 32'h0);
        chk("tie1_dat1", r1_dat_o, 32'hA5A5_0001);
        tick();
        m_ack = 1'b0; r0_cyc = 1'b0; r0_stb = 1'b0;
        tick();
        chk("tie1_gap", 32'(grant), 32'h0);
        tick();
        chk("tie1_r1_grant", 32'(grant), 32'h2);
        chk("tie1_r1_adr", m_adr, 32'h200);
        r1_cyc = 1'b0; r1_stb = 1'b0;
        tick();
        chk("tie2_idle", 32'(grant), 32'h0);
        r0_cyc = 1'b1; r0_stb = 1'b1; r1_cyc = 1'b1; r1_stb = 1'b1;
        tick();
        chk("tie2_grant", 32'(grant), 32'h1);
        r0_cyc = 1'b0; r0_stb = 1'b0; r1_cyc = 1'b0; r1_stb = 1'b0;
        tick();
        chk("tie2_idle_after", 32'(grant), 32'h0);

        // r1 4-beat incrementing burst, r0 requests mid-burst
        r1_cyc = 1'b1; r1_stb = 1'b1; r1_cti = 3'b010; r1_bte = 2'b00;
        tick();
        chk("bst_grant", 32'(grant), 32'h2);
        for (int b = 0; b < 4; b++) begin
            r1_cti = (b == 3) ? 3'b111 : 3'b010;
            if (b >= 1) begin
                r0_cyc = 1'b1; r0_stb = 1'b1;
            end
            m_ack = 1'b1; settle();
            chk("bst_ack1", 32'(r1_ack_o), 32'h1);
            chk("bst_ack0", 32'(r0_ack_o), 32'h0);
            chk("bst_hold", 32'(grant), 32'h2);
            chk("bst_cti", 32'(m_cti), 32'(r1_cti));
            tick();
        end
        m_ack = 1'b0; r1_cyc = 1'b0; r1_stb = 1'b0; r1_cti = 3'b000; settle();
        chk("bst_rel_cyc", 32'(m_cyc), 32'h0);
        tick();
        chk("bst_gap", 32'(grant), 32'h0);
        tick();
        chk("bst_r0_grant", 32'(grant), 32'h1);

        // Watchdog: r0 owns with strobe up and no slave response (stall 1 now)
        for (int k = 1; k < 8; k++) begin
            chk("wd_pre_err", 32'(r0_err_o), 32'h0);
            chk("wd_pre_to", 32'(timeout), 32'h0);
            tick();
        end
        chk("wd_fire_err0", 32'(r0_err_o), 32'h1);
        chk("wd_fire_err1", 32'(r1_err_o), 32'h0);
        chk("wd_fire_ack0", 32'(r0_ack_o), 32'h0);
        chk("wd_fire_to", 32'(timeout), 32'h0);
        tick();
        chk("wd_to_pulse", 32'(timeout), 32'h1);
        chk("wd_err_off", 32'(r0_err_o), 32'h0);
        chk("wd_cnt_clr", 32'(dut.wd_cnt_q), 32'h0);
        chk("wd_keep_cyc", 32'(m_cyc), 32'h1);
        tick();
        chk("wd_to_off", 32'(timeout), 32'h0);
        r0_cyc = 1'b0; r0_stb = 1'b0;
        tick();
        chk("wd_rel_grant", 32'(grant), 32'h0);

        // Slave ack and err together on an r1 read
        r1_cyc = 1'b1; r1_stb = 1'b1; r1_we = 1'b0;
        tick();
        chk("ae_grant", 32'(grant), 32'h2);
        m_ack = 1'b1; m_err = 1'b1; m_dat_i = 32'h12345678; settle();
        chk("ae_err1", 32'(r1_err_o), 32'h1);
        chk("ae_ack1", 32'(r1_ack_o), 32'h0);
        chk("ae_err0", 32'(r0_err_o), 32'h0);
        chk("ae_dat1", r1_dat_o, 32'h12345678);
        chk("ae_to", 32'(timeout), 32'h0);
        tick();
        m_ack = 1'b0; m_err = 1'b0; r1_cyc = 1'b0; r1_stb = 1'b0; settle();
        chk("ae_to_after", 32'(timeout), 32'h0);
        tick();

        // Reset in the middle of an r0 burst
        r0_cyc = 1'b1; r0_stb = 1'b1; r0_cti = 3'b010;
        tick();
        chk("mr_grant", 32'(grant), 32'h1);
        m_ack = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; settle();
        chk("mr_cyc", 32'(m_cyc), 32'h0);
        chk("mr_grant0", 32'(grant), 32'h0);
        chk("mr_wdcnt", 32'(dut.wd_cnt_q), 32'h0);
        chk("mr_ack_drop", 32'(r0_ack_o), 32'h0);
        tick();
        m_ack = 1'b0; settle();
        chk("mr_regrant", 32'(grant), 32'h1);
        chk("mr_regrant_cyc", 32'(m_cyc), 32'h1);
        r0_cyc = 1'b0; r0_stb = 1'b0;
        tick();
        chk("mr_final_idle", 32'(grant), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout_guard: observed no finish expected finish");
        $fatal(1, "simulation time bound expired");
    end

endmodule
